hwpe_stream_sink_packer: RTL and testbench



---
 rtl/hwpe_stream_package.sv | 11 +
 rtl/hwpe_stream_sink_packer.sv | 117 +++++++++++
 tb/tb_hwpe_stream_sink_packer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_package.sv
// Shared HWPE stream definitions: packer flag bundle and default counter width.
package hwpe_stream_package;

    localparam int unsigned HWPE_STREAM_PACKER_CNT_WIDTH = 16;

    typedef struct packed {
        logic [HWPE_STREAM_PACKER_CNT_WIDTH-1:0] word_count;
        logic                                    done;
    } flags_packer_t;

endpackage

// File: rtl/hwpe_stream_sink_packer.sv
// Packs narrow IN_WIDTH beats into strobed OUT_WIDTH words for the sink streamer.
// Define HWPE_STREAM_PACKER_MSB_FIRST_EN to place the first beat in the MSB lane.
module hwpe_stream_sink_packer
    import hwpe_stream_package::*;
#(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = HWPE_STREAM_PACKER_CNT_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   push_valid_i,
    input  logic [IN_WIDTH-1:0]    push_data_i,
    input  logic                   push_last_i,
    output logic                   push_ready_o,
    output logic                   pop_valid_o,
    output logic [OUT_WIDTH-1:0]   pop_data_o,
    output logic [OUT_WIDTH/8-1:0] pop_strb_o,
    input  logic                   pop_ready_i,
    output logic [CNT_WIDTH-1:0]   word_count_o,
    output logic                   done_o
);

    localparam int unsigned RATIO    = OUT_WIDTH / IN_WIDTH;
    localparam int unsigned IN_BYTES = IN_WIDTH / 8;
    localparam int unsigned STRB_W   = OUT_WIDTH / 8;
    localparam int unsigned LANE_W   = $clog2(RATIO);

    function automatic int unsigned lane_slot(input logic [LANE_W-1:0] k);
`ifdef HWPE_STREAM_PACKER_MSB_FIRST_EN
        return RATIO - 1 - 32'(k);
`else
        return 32'(k);
`endif
    endfunction

    logic [OUT_WIDTH-1:0] accum_data_q;
    logic [STRB_W-1:0]    accum_strb_q;
    logic [LANE_W-1:0]    lane_q;
    logic [OUT_WIDTH-1:0] out_data_q;
    logic [STRB_W-1:0]    out_strb_q;
    logic                 out_valid_q;
    logic                 out_last_q;
    logic [CNT_WIDTH-1:0] word_count_q;
    logic                 done_q;

    logic                 completing;
    logic                 accept;
    logic                 pop;
    logic [OUT_WIDTH-1:0] beat_data;
    logic [STRB_W-1:0]    beat_strb;

    always_comb begin
        completing   = push_last_i | (lane_q == LANE_W'(RATIO - 1));
        // Only a completing beat needs room in the output register.
        push_ready_o = completing ? (~out_valid_q | pop_ready_i) : 1'b1;
        accept       = push_valid_i & push_ready_o;
        pop          = out_valid_q & pop_ready_i;
        beat_data    = OUT_WIDTH'(push_data_i) << (lane_slot(lane_q) * IN_WIDTH);
        beat_strb    = STRB_W'({IN_BYTES{1'b1}}) << (lane_slot(lane_q) * IN_BYTES);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            accum_data_q <= '0;
            accum_strb_q <= '0;
            lane_q       <= '0;
            out_data_q   <= '0;
            out_strb_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            word_count_q <= '0;
            done_q       <= 1'b0;
        end else if (clear_i) begin
            accum_data_q <= '0;
            accum_strb_q <= '0;
            lane_q       <= '0;
            out_data_q   <= '0;
            out_strb_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            word_count_q <= '0;
            done_q       <= 1'b0;
        end else begin
            if (accept && completing) begin
                out_data_q   <= accum_data_q | beat_data;
                out_strb_q   <= accum_strb_q | beat_strb;
                out_valid_q  <= 1'b1;
                out_last_q   <= push_last_i;
                accum_data_q <= '0;
                accum_strb_q <= '0;
                lane_q       <= '0;
            end else begin
                if (accept) begin
                    accum_data_q <= accum_data_q | beat_data;
                    accum_strb_q <= accum_strb_q | beat_strb;
                    lane_q       <= lane_q + LANE_W'(1);
                end
                if (pop) begin
                    out_valid_q <= 1'b0;
                end
            end
            if (pop) begin
                word_count_q <= word_count_q + CNT_WIDTH'(1);
            end
            done_q <= pop & out_last_q;
        end
    end

    assign pop_valid_o  = out_valid_q;
    assign pop_data_o   = out_data_q;
    assign pop_strb_o   = out_strb_q;
    assign word_count_o = word_count_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_hwpe_stream_sink_packer.sv
// Directed self-checking bench for hwpe_stream_sink_packer (IN=8, OUT=32).
module tb_hwpe_stream_sink_packer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        clear_i = 1'b0;
    logic        push_valid_i = 1'b0;
    logic [7:0]  push_data_i = '0;
    logic        push_last_i = 1'b0;
    logic        push_ready_o;
    logic        pop_valid_o;
    logic [31:0] pop_data_o;
    logic [3:0]  pop_strb_o;
    logic        pop_ready_i = 1'b0;
    logic [15:0] word_count_o;
    logic        done_o;

    int n_checks = 0;
    int n_errors = 0;

    hwpe_stream_sink_packer #(
        .IN_WIDTH  (8),
        .OUT_WIDTH (32),
        .CNT_WIDTH (16)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (clear_i),
        .push_valid_i (push_valid_i),
        .push_data_i  (push_data_i),
        .push_last_i  (push_last_i),
        .push_ready_o (push_ready_o),
        .pop_valid_o  (pop_valid_o),
        .pop_data_o   (pop_data_o),
        .pop_strb_o   (pop_strb_o),
        .pop_ready_i  (pop_ready_i),
        .word_count_o (word_count_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the beat was taken.
    task automatic send_beat(input logic [7:0] d, input logic last);
        int n = 0;
        push_valid_i = 1'b1;
        push_data_i  = d;
        push_last_i  = last;
        #1;
        while (!push_ready_o && n < 20) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (!push_ready_o) check_eq("accept_timeout", {31'd0, push_ready_o}, 32'd1);
        @(posedge clk_i);
        #1;
        push_valid_i = 1'b0;
        push_last_i  = 1'b0;
    endtask

`ifdef HWPE_STREAM_PACKER_MSB_FIRST_EN
    localparam logic [31:0] W1 = 32'h11223344, W2 = 32'hAABB0000, W3A = 32'h01020304;
    localparam logic [31:0] W3B = 32'h05060708, W4 = 32'hA1A2A3A4, W6 = 32'h55000000;
    localparam logic [3:0]  S2 = 4'hC, S6 = 4'h8;
`else
    localparam logic [31:0] W1 = 32'h44332211, W2 = 32'h0000BBAA, W3A = 32'h04030201;
    localparam logic [31:0] W3B = 32'h08070605, W4 = 32'hA4A3A2A1, W6 = 32'h00000055;
    localparam logic [3:0]  S2 = 4'h3, S6 = 4'h1;
`endif

    initial begin
        #12 rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_eq("rst_valid", {31'd0, pop_valid_o}, 32'd0);
        check_eq("rst_data", pop_data_o, 32'd0);
        check_eq("rst_strb", {28'd0, pop_strb_o}, 32'd0);
        check_eq("rst_count", {16'd0, word_count_o}, 32'd0);
        check_eq("rst_done", {31'd0, done_o}, 32'd0);

        // Full word, sink always ready
        pop_ready_i = 1'b1;
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        check_eq("t1_not_yet", {31'd0, pop_valid_o}, 32'd0);
        send_beat(8'h44, 1'b0);
        check_eq("t1_valid", {31'd0, pop_valid_o}, 32'd1);
        check_eq("t1_data", pop_data_o, W1);
        check_eq("t1_strb", {28'd0, pop_strb_o}, 32'hF);
        @(posedge clk_i);
        #1;
        check_eq("t1_popped", {31'd0, pop_valid_o}, 32'd0);
        check_eq("t1_count", {16'd0, word_count_o}, 32'd1);
        check_eq("t1_no_done", {31'd0, done_o}, 32'd0);

        // Partial word flushed by last
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b1);
        check_eq("t2_valid", {31'd0, pop_valid_o}, 32'd1);
        check_eq("t2_data", pop_data_o, W2);
        check_eq("t2_strb", {28'd0, pop_strb_o}, {28'd0, S2});
        @(posedge clk_i);
        #1;
        check_eq("t2_done", {31'd0, done_o}, 32'd1);
        check_eq("t2_count", {16'd0, word_count_o}, 32'd2);
        @(posedge clk_i);
        #1;
        check_eq("t2_done_drop", {31'd0, done_o}, 32'd0);

        // Backpressure on the pop side
        pop_ready_i = 1'b0;
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h03, 1'b0);
        send_beat(8'h04, 1'b0);
        check_eq("t3_pending", {31'd0, pop_valid_o}, 32'd1);
        send_beat(8'h05, 1'b0);
        send_beat(8'h06, 1'b0);
        send_beat(8'h07, 1'b0);
        push_valid_i = 1'b1;
        push_data_i  = 8'h08;
        #1;
        check_eq("t3_stall", {31'd0, push_ready_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("t3_still_stall", {31'd0, push_ready_o}, 32'd0);
        check_eq("t3_stable_data", pop_data_o, W3A);
        check_eq("t3_stable_strb", {28'd0, pop_strb_o}, 32'hF);
        pop_ready_i = 1'b1;
        #1;
        check_eq("t3_ready", {31'd0, push_ready_o}, 32'd1);
        @(posedge clk_i);
        #1;
        push_valid_i = 1'b0;
        check_eq("t3_b2b_valid", {31'd0, pop_valid_o}, 32'd1);
        check_eq("t3_b2b_data", pop_data_o, W3B);
        check_eq("t3_b2b_count", {16'd0, word_count_o}, 32'd3);
        @(posedge clk_i);
        #1;
        check_eq("t3_drained", {31'd0, pop_valid_o}, 32'd0);
        check_eq("t3_count_end", {16'd0, word_count_o}, 32'd4);

        // Asynchronous reset mid-word
        send_beat(8'h10, 1'b0);
        send_beat(8'h20, 1'b0);
        #2 rst_i = 1'b1;
        #1;
        check_eq("t4_rst_count", {16'd0, word_count_o}, 32'd0);
        check_eq("t4_rst_valid", {31'd0, pop_valid_o}, 32'd0);
        check_eq("t4_rst_data", pop_data_o, 32'd0);
        #3 rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        send_beat(8'hA1, 1'b0);
        send_beat(8'hA2, 1'b0);
        send_beat(8'hA3, 1'b0);
        send_beat(8'hA4, 1'b0);
        check_eq("t4_clean_data", pop_data_o, W4);
        check_eq("t4_clean_strb", {28'd0, pop_strb_o}, 32'hF);
        @(posedge clk_i);
        #1;
        check_eq("t4_count", {16'd0, word_count_o}, 32'd1);

        // Synchronous clear with a word pending
        pop_ready_i = 1'b0;
        send_beat(8'hC1, 1'b0);
        send_beat(8'hC2, 1'b0);
        send_beat(8'hC3, 1'b0);
        send_beat(8'hC4, 1'b0);
        check_eq("t5_pending", {31'd0, pop_valid_o}, 32'd1);
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        check_eq("t5_clr_valid", {31'd0, pop_valid_o}, 32'd0);
        check_eq("t5_clr_count", {16'd0, word_count_o}, 32'd0);
        check_eq("t5_clr_data", pop_data_o, 32'd0);

        // Last beat on lane 0
        send_beat(8'h55, 1'b1);
        check_eq("t6_valid", {31'd0, pop_valid_o}, 32'd1);
        check_eq("t6_data", pop_data_o, W6);
        check_eq("t6_strb", {28'd0, pop_strb_o}, {28'd0, S6});
        pop_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_eq("t6_done", {31'd0, done_o}, 32'd1);
        check_eq("t6_count", {16'd0, word_count_o}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
